// File: rtl/machina_pkg.sv
// Shared types for the perceptron training supervisor: FSM states, the
// default-width sample layout and the error word width.
package machina_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ARG,
    ST_RES,
    ST_ERR,
    ST_FBK,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int ERR_W = 16;
  localparam int SMP_N = 2;

  // Wire layout of one training sample: argument lanes above, target in the low byte.
  typedef struct packed {
    logic [SMP_N-1:0][7:0] arg;
    logic [7:0]            tgt;
  } sample_t;

endpackage

// File: rtl/sample_mem.sv
// Training-set register file: one synchronous write port, one combinational read port.
// Write lands on the clock edge; reads see stored contents with zero latency, no backpressure.
module sample_mem
  import machina_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [N*8+7:0]             wr_dat,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [N*8+7:0]             rd_dat
);

  logic [N*8+7:0] mem_q [DEPTH];
  logic [N*8+7:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/supervisor.sv
// Replays a stored training set through a perceptron for N epochs, then scores one eval epoch.
// All outputs registered; every stream stalls indefinitely on its peer's stb/rdy.
module supervisor
  import machina_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int TOL   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         smp_stb,
  output logic                         smp_rdy,
  input  logic [N*8+7:0]               smp_dat,
  input  logic                         run_stb,
  output logic                         run_rdy,
  input  logic [7:0]                   run_dat,
  output logic                         done_stb,
  input  logic                         done_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   done_dat,
  output logic                         arg_stb,
  input  logic                         arg_rdy,
  output logic [N*8-1:0]               arg_dat,
  input  logic                         res_stb,
  output logic                         res_rdy,
  input  logic [7:0]                   res_dat,
  output logic                         err_stb,
  input  logic                         err_rdy,
  output logic [ERR_W-1:0]             err_dat,
  input  logic                         fbk_stb,
  output logic                         fbk_rdy,
  input  logic [N*16-1:0]              fbk_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = N*8+8;
  localparam logic [8:0] TOL_L = 9'(TOL);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, miss_q, miss_d, done_dat_q, done_dat_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [7:0]      epoch_q, epoch_d;
  logic            eval_q, eval_d;
  logic [N*8-1:0]  arg_dat_q, arg_dat_d;
  logic [ERR_W-1:0] err_dat_q, err_dat_d;
  logic smp_rdy_q, smp_rdy_d, run_rdy_q, run_rdy_d, arg_stb_q, arg_stb_d;
  logic res_rdy_q, res_rdy_d, err_stb_q, err_stb_d, fbk_rdy_q, fbk_rdy_d;
  logic done_stb_q, done_stb_d;

  logic          smp_fire, run_fire, arg_fire, res_fire, err_fire, fbk_fire, done_fire;
  logic          mem_we;
  logic [W-1:0]  rd_dat, arg_src;
  logic [8:0]    diff, mag;
  logic [CW-1:0] idx_ext;
  logic          fbk_unused;

  assign smp_fire  = smp_stb  & smp_rdy_q;
  assign run_fire  = run_stb  & run_rdy_q;
  assign arg_fire  = arg_stb_q & arg_rdy;
  assign res_fire  = res_stb  & res_rdy_q;
  assign err_fire  = err_stb_q & err_rdy;
  assign fbk_fire  = fbk_stb  & fbk_rdy_q;
  assign done_fire = done_stb_q & done_rdy;
  assign fbk_unused = ^fbk_dat;

  sample_mem #(.N(N), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_dat  (smp_dat),
    .rd_addr (idx_d),
    .rd_dat  (rd_dat)
  );

  // A sample stored on the same edge that starts a run must reach arg_dat directly.
  assign arg_src = (smp_fire && cnt_q[AW-1:0] == idx_d) ? smp_dat : rd_dat;

  assign diff    = {1'b0, rd_dat[7:0]} - {1'b0, res_dat};
  assign mag     = diff[8] ? (~diff + 9'd1) : diff;
  assign idx_ext = CW'(idx_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    eval_d     = eval_q;
    miss_d     = miss_q;
    err_dat_d  = err_dat_q;
    arg_dat_d  = arg_dat_q;
    done_dat_d = done_dat_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (smp_fire) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
        if (run_fire) begin
          epoch_d = run_dat;
          idx_d   = '0;
          miss_d  = '0;
          eval_d  = (run_dat == 8'd0);
          state_d = ST_ARG;
        end
      end
      ST_ARG: if (arg_fire) state_d = ST_RES;
      ST_RES: begin
        if (res_fire) begin
          if (eval_q) begin
            if (mag > TOL_L) miss_d = miss_q + CW'(1);
            state_d = ST_NEXT;
          end else begin
            err_dat_d = {{(ERR_W-9){diff[8]}}, diff};
            state_d   = ST_ERR;
          end
        end
      end
      ST_ERR: if (err_fire) state_d = ST_FBK;
      ST_FBK: if (fbk_fire) state_d = ST_NEXT;
      ST_NEXT: begin
        state_d = ST_ARG;
        if (idx_ext == cnt_q - CW'(1)) begin
          idx_d = '0;
          if (eval_q) begin
            state_d = ST_DONE;
          end else begin
            epoch_d = epoch_q - 8'd1;
            if (epoch_q == 8'd1) eval_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_DONE: if (done_fire) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase

    if (state_d == ST_ARG)  arg_dat_d  = arg_src[W-1:8];
    if (state_d == ST_DONE) done_dat_d = miss_d;

    smp_rdy_d  = (state_d == ST_LOAD) && (cnt_d < CW'(DEPTH));
    run_rdy_d  = (state_d == ST_LOAD) && (cnt_d != '0);
    arg_stb_d  = (state_d == ST_ARG);
    res_rdy_d  = (state_d == ST_RES);
    err_stb_d  = (state_d == ST_ERR);
    fbk_rdy_d  = (state_d == ST_FBK);
    done_stb_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      idx_q      <= '0;
      epoch_q    <= '0;
      eval_q     <= 1'b0;
      miss_q     <= '0;
      err_dat_q  <= '0;
      arg_dat_q  <= '0;
      done_dat_q <= '0;
      smp_rdy_q  <= 1'b0;
      run_rdy_q  <= 1'b0;
      arg_stb_q  <= 1'b0;
      res_rdy_q  <= 1'b0;
      err_stb_q  <= 1'b0;
      fbk_rdy_q  <= 1'b0;
      done_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      epoch_q    <= epoch_d;
      eval_q     <= eval_d;
      miss_q     <= miss_d;
      err_dat_q  <= err_dat_d;
      arg_dat_q  <= arg_dat_d;
      done_dat_q <= done_dat_d;
      smp_rdy_q  <= smp_rdy_d;
      run_rdy_q  <= run_rdy_d;
      arg_stb_q  <= arg_stb_d;
      res_rdy_q  <= res_rdy_d;
      err_stb_q  <= err_stb_d;
      fbk_rdy_q  <= fbk_rdy_d;
      done_stb_q <= done_stb_d;
    end
  end

  assign smp_rdy  = smp_rdy_q;
  assign run_rdy  = run_rdy_q;
  assign arg_stb  = arg_stb_q;
  assign arg_dat  = arg_dat_q;
  assign res_rdy  = res_rdy_q;
  assign err_stb  = err_stb_q;
  assign err_dat  = err_dat_q;
  assign fbk_rdy  = fbk_rdy_q;
  assign done_stb = done_stb_q;
  assign done_dat = done_dat_q;

endmodule

// File: tb/tb_supervisor.sv
// Bench for supervisor: behavioural perceptron stub on the forward/backward streams,
// scoreboard queues filled at run issue and drained as transfers appear.
module tb_supervisor;
  import machina_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int TOL   = 0;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            smp_stb = 1'b0, smp_rdy;
  logic [N*8+7:0]  smp_dat = '0;
  logic            run_stb = 1'b0, run_rdy;
  logic [7:0]      run_dat = '0;
  logic            done_stb, done_rdy = 1'b0;
  logic [CW-1:0]   done_dat;
  logic            arg_stb, arg_rdy;
  logic [N*8-1:0]  arg_dat;
  logic            res_stb, res_rdy;
  logic [7:0]      res_dat;
  logic            err_stb, err_rdy;
  logic [15:0]     err_dat;
  logic            fbk_stb, fbk_rdy;
  logic [N*16-1:0] fbk_dat;

  always #5 clk = ~clk;

  supervisor #(.N(N), .DEPTH(DEPTH), .TOL(TOL)) dut (
    .clk(clk), .rst(rst),
    .smp_stb(smp_stb), .smp_rdy(smp_rdy), .smp_dat(smp_dat),
    .run_stb(run_stb), .run_rdy(run_rdy), .run_dat(run_dat),
    .done_stb(done_stb), .done_rdy(done_rdy), .done_dat(done_dat),
    .arg_stb(arg_stb), .arg_rdy(arg_rdy), .arg_dat(arg_dat),
    .res_stb(res_stb), .res_rdy(res_rdy), .res_dat(res_dat),
    .err_stb(err_stb), .err_rdy(err_rdy), .err_dat(err_dat),
    .fbk_stb(fbk_stb), .fbk_rdy(fbk_rdy), .fbk_dat(fbk_dat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model state and scoreboard
  sample_t     mset[$];
  logic [15:0] arg_q[$];
  logic [15:0] err_q[$];
  int          done_q[$];
  int          res_mode = 2;   // 0: res=00, 1: res=ff, 2: AND of lanes
  bit          arg_stall = 0, err_stall = 0, fbk_block = 0;
  int          err_seen = 0;
  logic [15:0] last_err = '0;

  function automatic logic [7:0] stub_res(input logic [15:0] a);
    case (res_mode)
      0:       return 8'h00;
      1:       return 8'hff;
      default: return (a == 16'hffff) ? 8'hff : 8'h00;
    endcase
  endfunction

  function automatic sample_t mk(input logic [15:0] a, input logic [7:0] t);
    return sample_t'({a, t});
  endfunction

  task automatic push_expected(input logic [7:0] ep);
    int miss, d;
    miss = 0;
    for (int e = 0; e < int'(ep); e++) begin
      foreach (mset[i]) begin
        arg_q.push_back(mset[i].arg);
        err_q.push_back(16'(int'(mset[i].tgt) - int'(stub_res(mset[i].arg))));
      end
    end
    foreach (mset[i]) begin
      arg_q.push_back(mset[i].arg);
      d = int'(mset[i].tgt) - int'(stub_res(mset[i].arg));
      if (d < 0) d = -d;
      if (d > TOL) miss++;
    end
    done_q.push_back(miss);
  endtask

  // Perceptron stub: answers arg with res, err with fbk; checks streams against the scoreboard.
  int          aw = 0, ew = 0;
  logic [15:0] ahold, ehold, lastarg;
  bit          af, rf, ef, ff, fbk_pend;
  initial begin : stub
    arg_rdy = 1'b1; err_rdy = 1'b1; res_stb = 1'b0; res_dat = '0;
    fbk_stb = 1'b0; fbk_dat = '0; fbk_pend = 1'b0; lastarg = '0;
    forever begin
      @(negedge clk);
      af = arg_stb && arg_rdy;
      rf = res_stb && res_rdy;
      ef = err_stb && err_rdy;
      ff = fbk_stb && fbk_rdy;
      if (arg_stb || res_rdy || err_stb || fbk_rdy)
        chk("one_active", $countones({arg_stb, res_rdy, err_stb, fbk_rdy}), 1);
      if (arg_stb) begin
        aw++;
        if (aw == 1) ahold = arg_dat; else chk("arg_hold", arg_dat, ahold);
      end
      if (err_stb) begin
        ew++;
        if (ew == 1) ehold = err_dat; else chk("err_hold", err_dat, ehold);
      end
      if (af) begin
        chk("arg_expected", arg_q.size() > 0, 1);
        if (arg_q.size() > 0) chk("arg_dat", arg_dat, arg_q.pop_front());
        lastarg = arg_dat;
        aw = 0;
      end
      if (ef) begin
        chk("err_expected", err_q.size() > 0, 1);
        if (err_q.size() > 0) chk("err_dat", err_dat, err_q.pop_front());
        last_err = err_dat;
        err_seen++;
        ew = 0;
      end
      @(posedge clk); #1;
      if (!rst) begin
        res_stb = 1'b0; fbk_stb = 1'b0; fbk_pend = 1'b0; aw = 0; ew = 0;
        continue;
      end
      if (rf) res_stb = 1'b0;
      if (af) begin res_stb = 1'b1; res_dat = stub_res(lastarg); end
      if (ff) fbk_stb = 1'b0;
      if (ef) fbk_pend = 1'b1;
      if (fbk_pend && !fbk_block) begin
        fbk_stb = 1'b1; fbk_dat = $urandom; fbk_pend = 1'b0;
      end
      arg_rdy = !arg_stall || (aw >= 5);
      err_rdy = !err_stall || (ew >= 5);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stb_rdy", {smp_rdy, run_rdy, arg_stb, res_rdy, err_stb, fbk_rdy, done_stb}, 0);
    mset.delete(); arg_q.delete(); err_q.delete(); done_q.delete();
    smp_stb = 1'b0; run_stb = 1'b0; done_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_smp_rdy", smp_rdy, 1);
    chk("post_rst_run_rdy", run_rdy, 0);
  endtask

  task automatic host_xfer(input bit do_smp, input sample_t s, input bit do_run, input logic [7:0] ep);
    bit sdone, rdone, sf, rfire;
    int n;
    if (do_smp) mset.push_back(s);
    if (do_run) push_expected(ep);
    @(posedge clk); #1;
    smp_stb = do_smp; smp_dat = s; run_stb = do_run; run_dat = ep;
    sdone = !do_smp; rdone = !do_run; n = 0;
    while (!(sdone && rdone) && n < 50) begin
      @(negedge clk);
      sf    = smp_stb && smp_rdy;
      rfire = run_stb && run_rdy;
      @(posedge clk); #1;
      if (sf)    begin smp_stb = 1'b0; sdone = 1'b1; end
      if (rfire) begin run_stb = 1'b0; rdone = 1'b1; end
      n++;
    end
    chk("smp_accept", sdone, 1);
    chk("run_accept", rdone, 1);
    smp_stb = 1'b0; run_stb = 1'b0;
  endtask

  task automatic wait_done(input int hold);
    int n, exp;
    n = 0;
    do begin @(negedge clk); n++; end while (!done_stb && n < 4000);
    chk("done_seen", done_stb, 1);
    if (!done_stb) return;
    exp = (done_q.size() > 0) ? done_q.pop_front() : -1;
    chk("done_dat", done_dat, exp);
    repeat (hold) begin
      @(negedge clk);
      chk("done_hold_stb", done_stb, 1);
      chk("done_hold_dat", done_dat, exp);
    end
    @(posedge clk); #1; done_rdy = 1'b1;
    @(negedge clk); chk("done_xfer_stb", done_stb, 1);
    @(posedge clk); #1; done_rdy = 1'b0;
    @(negedge clk);
    chk("done_dropped", done_stb, 0);
    chk("rerun_ready", run_rdy, 1);
    chk("arg_q_drained", arg_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
  endtask

  task automatic load_and();
    host_xfer(1, mk(16'h0000, 8'h00), 0, 0);
    host_xfer(1, mk(16'h00ff, 8'h00), 0, 0);
    host_xfer(1, mk(16'hff00, 8'h00), 0, 0);
    host_xfer(1, mk(16'hffff, 8'hff), 0, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int e0, n;
    #2;
    rst = 1'b0;
    #1;
    chk("init_outs", {smp_rdy, run_rdy, arg_stb, res_rdy, err_stb, fbk_rdy, done_stb}, 0);
    chk("init_dat", {arg_dat, err_dat, 29'(done_dat)}, 0);
    @(negedge clk); rst = 1'b1;

    // AND set trained for 10 epochs, held done, then rerun without reload
    do_reset();
    res_mode = 2;
    load_and();
    chk("full_smp_rdy", smp_rdy, 0);
    err_seen = 0;
    host_xfer(0, mk(0, 0), 1, 8'd10);
    wait_done(3);
    chk("and_err_count", err_seen, 40);
    host_xfer(0, mk(0, 0), 1, 8'd0);
    wait_done(0);
    chk("rerun_no_err", err_seen, 40);

    // Evaluation-only misses with constant stubs
    e0 = err_seen;
    res_mode = 0;
    host_xfer(0, mk(0, 0), 1, 8'd0);
    wait_done(0);
    res_mode = 1;
    host_xfer(0, mk(0, 0), 1, 8'd0);
    wait_done(0);
    chk("eval_no_err", err_seen, e0);

    // Error sign extension with stalled arg/err streams
    do_reset();
    arg_stall = 1; err_stall = 1;
    res_mode = 0;
    host_xfer(1, mk(16'h1234, 8'hff), 1, 8'd1);
    wait_done(0);
    chk("err_pos", last_err, 16'h00ff);
    do_reset();
    res_mode = 1;
    host_xfer(1, mk(16'h5a5a, 8'h00), 1, 8'd1);
    wait_done(0);
    chk("err_neg", last_err, 16'hff01);
    arg_stall = 0; err_stall = 0;

    // Capacity limit and run/sample interplay
    do_reset();
    chk("run_rdy_empty", run_rdy, 0);
    res_mode = 2;
    load_and();
    @(posedge clk); #1;
    smp_stb = 1'b1; smp_dat = mk(16'h1111, 8'h22);
    repeat (4) begin @(negedge clk); chk("smp_rdy_full", smp_rdy, 0); end
    @(posedge clk); #1; smp_stb = 1'b0;
    host_xfer(0, mk(0, 0), 1, 8'd2);
    wait_done(0);
    do_reset();
    host_xfer(1, mk(16'hffff, 8'h40), 1, 8'd3);
    wait_done(0);
    do_reset();
    host_xfer(1, mk(16'h0102, 8'h10), 0, 0);
    host_xfer(1, mk(16'hffff, 8'hff), 1, 8'd2);
    wait_done(0);

    // Maximum epoch count on a single sample
    do_reset();
    res_mode = 1;
    e0 = err_seen;
    host_xfer(1, mk(16'h0f0f, 8'h80), 1, 8'd255);
    wait_done(0);
    chk("ep255_err_count", err_seen - e0, 255);
    chk("ep255_err_val", last_err, 16'hff81);

    // Reset while waiting in FBK
    do_reset();
    res_mode = 2;
    load_and();
    fbk_block = 1;
    host_xfer(0, mk(0, 0), 1, 8'd10);
    n = 0;
    do begin @(negedge clk); n++; end while (!fbk_rdy && n < 100);
    chk("fbk_reached", fbk_rdy, 1);
    rst = 1'b0;
    #1;
    chk("midrun_rst_outs", {smp_rdy, run_rdy, arg_stb, res_rdy, err_stb, fbk_rdy, done_stb}, 0);
    chk("midrun_rst_dat", {arg_dat, err_dat}, 0);
    mset.delete(); arg_q.delete(); err_q.delete(); done_q.delete();
    fbk_block = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("after_rst_run_rdy", run_rdy, 0);
    chk("after_rst_smp_rdy", smp_rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
